cpu_mul_seq: RTL and testbench
==============================

Name: cpu_mul_seq

Overview:
- Two-pass sequencer for a 32x32 multiply returning the low 32 bits of the product. It sits directly upstream and downstream of the multiplier cell (cpu_mult_cell).
- The cell computes a_lo*b_lo + ((a_hi*b_lo)<<16) with one registered stage, which omits the a_lo*b_hi term. This block issues a second pass for that term and accumulates it.
- It drives the cell's operand inputs and consumes the cell's result. Between it and the cell it presents a start/busy/result_valid handshake to the execute stage.

Parameters:
- EARLY_OUT, 1, when 1, skip pass 2 if src2[31:16]==0 (the missing term is then zero).

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy==0
- src1  in  32  operand A; captured on an accepted start
- src2  in  32  operand B; captured on an accepted start
- flush  in  1  abort any operation in flight
- busy  out  1  high whenever state!=IDLE
- result_valid  out  1  one-cycle pulse; result is valid in that cycle
- result  out  32  low 32 bits of A*B; held until the next result load
- M_mul_src1  out  32  cell operand 1
- M_mul_src2  out  32  cell operand 2
- M_mul_cell_result  in  32  cell product; reflects operands presented one cycle earlier

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, result_valid=0, result=0.
  - Operand registers, accumulator and M_mul_src1/2 all 0.
- States: IDLE, ISSUE1, ISSUE2, FINISH.
- IDLE:
  - start & ~flush: capture a_r=src1, b_r=src2; go to ISSUE1.
  - Otherwise remain in IDLE.
- ISSUE1:
  - Drive M_mul_src1=a_r, M_mul_src2=b_r; go to ISSUE2.
- ISSUE2:
  - Capture acc=M_mul_cell_result (pass-1 product).
  - If EARLY_OUT && b_r[31:16]==0: load result=M_mul_cell_result, pulse result_valid next cycle, go to IDLE.
  - Else: drive M_mul_src1={16'h0,a_r[15:0]}, M_mul_src2={16'h0,b_r[31:16]}; go to FINISH.
- FINISH:
  - Load result = acc + {M_mul_cell_result[15:0],16'h0}, modulo 2^32 (carry discarded).
  - Pulse result_valid next cycle; go to IDLE.
- M_mul_src1/2 are 0 in IDLE and FINISH, and in ISSUE2 when early-out is taken. They are decoded combinationally from the state and operand registers.
- Latency, with start accepted at the edge ending cycle 0:
  - full path: result_valid in cycle 4;
  - early-out path: result_valid in cycle 3.
- result_valid is asserted in a cycle where state==IDLE and busy==0, so a new start is accepted in that same cycle (back-to-back, 4-cycle throughput).
- start while busy: ignored and not queued. The caller must hold start until busy==0.
- flush:
  - In any state: go to IDLE next edge; suppress the pending result load and result_valid; result keeps its previous value.
  - flush together with start in IDLE: flush wins, nothing is captured.
  - flush in the cycle result_valid is high does not retract the pulse.
- Reset asserted mid-operation: immediate return to reset values; no result_valid pulse.
- All arithmetic is unsigned. Signed low-32 results are identical, so no sign handling is needed.

Test Plan:
1. Full path: src1=0x00010003, src2=0x00020005, start in cycle 0 -> busy high in cycles 1-3; result_valid only in cycle 4 with result=0x000B000F; M_mul_src2=0x00000002 during ISSUE2.
2. Early-out: src1=0xFFFFFFFF, src2=0x00000003, EARLY_OUT=1 -> result_valid in cycle 3, result=0xFFFFFFFD; FINISH never entered. With EARLY_OUT=0 -> same result in cycle 4.
3. Wrap-around: src1=src2=0xFFFFFFFF -> acc=0xFFFF0001 after pass 1; result=0x00000001 in cycle 4.
4. Start during busy: start with 0x2 x 0x3, then start with 0x5 x 0x7 asserted in cycles 1-3 and held into cycle 4 -> result 0x6 in cycle 4, second start accepted in cycle 4, result 0x23 in cycle 7 (early-out).
5. Flush in ISSUE2 with src1=0x00010003, src2=0x00020005 -> busy=0 next cycle; no result_valid; result retains its prior value. flush+start together in IDLE -> busy stays 0.
6. Reset asserted asynchronously mid-FINISH (between edges) -> busy, result_valid, result and M_mul_src1/2 go to 0 immediately; operation after reset release returns the correct product.

Source files
------------

// File: rtl/cpu_mul_seq.sv
// -----------------------------------------------------------------------------
// cpu_mul_seq
//   Two-pass sequencer around the 32x32 multiplier cell (cpu_mult_cell).
//   The cell returns a_lo*b_lo + ((a_hi*b_lo) << 16) one cycle after its
//   operands are presented, i.e. it leaves out the a_lo*b_hi cross term.
//   This block runs pass 1 with the full operands, then (unless b_hi is zero
//   and EARLY_OUT is set) runs pass 2 with {0,a_lo} x {0,b_hi} and adds the
//   low half of that product into the upper half of the pass-1 product.
//   The result is the low 32 bits of A*B (sign-agnostic).
//
// Parameters
//   EARLY_OUT          1: skip pass 2 when src2[31:16] == 0
//
// Ports
//   clk                clock, rising edge
//   reset              asynchronous, active-high reset
//   start              request, sampled only while busy == 0
//   src1, src2         operands, captured on an accepted start
//   flush              abort the operation in flight (wins over start)
//   busy               high whenever the sequencer is not idle
//   result_valid       one-cycle pulse marking a fresh result
//   result             low 32 bits of A*B, held until the next load
//   M_mul_src1/2       operands driven to the multiplier cell
//   M_mul_cell_result  cell product for operands presented one cycle earlier
// -----------------------------------------------------------------------------
module cpu_mul_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [31:0] M_mul_src1,
  output logic [31:0] M_mul_src2,
  input  logic [31:0] M_mul_cell_result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE1 = 2'd1,
    S_ISSUE2 = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [31:0] r_result;
  logic        r_valid;

  logic        w_cap;
  logic        w_acc_en;
  logic        w_load;
  logic [31:0] w_load_val;
  logic [31:0] w_src1;
  logic [31:0] w_src2;

  // Fold the pass-2 cross product into the upper half of the pass-1 product;
  // anything above bit 31 falls off, which is exactly the low-32 wrap.
  function automatic logic [31:0] f_accum(input logic [31:0] acc,
                                          input logic [15:0] cross_lo);
    return acc + {cross_lo, 16'h0000};
  endfunction

  always_comb begin
    w_next     = r_state;
    w_cap      = 1'b0;
    w_acc_en   = 1'b0;
    w_load     = 1'b0;
    w_load_val = 32'h0;
    w_src1     = 32'h0;
    w_src2     = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_cap  = 1'b1;
          w_next = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        w_src1 = r_a;
        w_src2 = r_b;
        w_next = S_ISSUE2;
      end
      S_ISSUE2: begin
        w_acc_en = 1'b1;
        if (EARLY_OUT && (r_b[31:16] == 16'h0000)) begin
          // Cross term is zero, so the pass-1 product is already final.
          w_load     = 1'b1;
          w_load_val = M_mul_cell_result;
          w_next     = S_IDLE;
        end else begin
          w_src1 = {16'h0000, r_a[15:0]};
          w_src2 = {16'h0000, r_b[31:16]};
          w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_load     = 1'b1;
        w_load_val = f_accum(r_acc, M_mul_cell_result[15:0]);
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort: drop whatever load was pending and fall back to idle.
    if (flush) begin
      w_next   = S_IDLE;
      w_acc_en = 1'b0;
      w_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_acc    <= 32'h0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_next;
      r_valid <= w_load;
      if (w_cap) begin
        r_a <= src1;
        r_b <= src2;
      end
      if (w_acc_en) begin
        r_acc <= M_mul_cell_result;
      end
      if (w_load) begin
        r_result <= w_load_val;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result_valid = r_valid;
  assign result       = r_result;
  assign M_mul_src1   = w_src1;
  assign M_mul_src2   = w_src2;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_mul_seq
//   Drives two sequencers (EARLY_OUT=0 and EARLY_OUT=1), each paired with a
//   behavioural model of the multiplier cell. Every accepted start pushes the
//   expected low-32 product and the cycle in which result_valid should pulse;
//   a monitor pops and compares whenever result_valid is seen.
// -----------------------------------------------------------------------------
module tb_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] src1 = 32'h0;
  logic [31:0] src2 = 32'h0;

  logic        busy0, busy1, valid0, valid1;
  logic [31:0] res0, res1, ms1_0, ms2_0, ms1_1, ms2_1;
  logic [31:0] cell0 = 32'h0;
  logic [31:0] cell1 = 32'h0;

  always #5 clk = ~clk;

  cpu_mul_seq #(.EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy0), .result_valid(valid0), .result(res0),
    .M_mul_src1(ms1_0), .M_mul_src2(ms2_0), .M_mul_cell_result(cell0)
  );

  cpu_mul_seq #(.EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy1), .result_valid(valid1), .result(res1),
    .M_mul_src1(ms1_1), .M_mul_src2(ms2_1), .M_mul_cell_result(cell1)
  );

  // Multiplier cell: one registered stage, omits the a_lo*b_hi term.
  function automatic logic [31:0] cell_fn(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p0, p1;
    p0 = {16'h0, a[15:0]} * {16'h0, b[15:0]};
    p1 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
    return p0 + (p1 << 16);
  endfunction

  always @(posedge clk) begin
    cell0 <= cell_fn(ms1_0, ms2_0);
    cell1 <= cell_fn(ms1_1, ms2_1);
  end

  // Reference: the true product, truncated.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    return p[31:0];
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0_unexpected_valid: result 0x%08h at cycle %0d, none pending", res0, cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0_result", res0, e.r);
        chk("dut0_valid_cycle", cyc, e.c);
      end
    end
    if (valid1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1_unexpected_valid: result 0x%08h at cycle %0d, none pending", res1, cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1_result", res1, e.r);
        chk("dut1_valid_cycle", cyc, e.c);
      end
    end
  end

  task automatic wait_idle(input bit d0, input bit d1);
    int n;
    n = 0;
    while (((d0 && busy0) || (d1 && busy1)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle_timeout: busy0=%0b busy1=%0b, required 0 within 50 cycles", busy0, busy1);
    end
  endtask

  // Issue at a falling edge with the targeted units idle; start is held for
  // exactly one cycle. Returns at the falling edge of the following cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit d0, input bit d1);
    exp_t e;
    wait_idle(d0, d1);
    src1 = a; src2 = b;
    start0 = d0; start1 = d1;
    e.r = ref_mul(a, b);
    if (d0) begin
      e.c = cyc + 4;
      q0.push_back(e);
    end
    if (d1) begin
      e.c = cyc + ((b[31:16] == 16'h0) ? 3 : 4);
      q1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Raise start on one unit immediately and hold it until that unit is idle.
  task automatic hold_issue(input logic [31:0] a, input logic [31:0] b, input bit which,
                            input int exp_accept);
    exp_t e;
    int n;
    src1 = a; src2 = b;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    n = 0;
    while ((which ? busy1 : busy0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "hold_accept_cycle_1" : "hold_accept_cycle_0", cyc, exp_accept);
    e.r = ref_mul(a, b);
    if (which) begin
      e.c = cyc + ((b[31:16] == 16'h0) ? 3 : 4);
      q1.push_back(e);
    end else begin
      e.c = cyc + 4;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_busy0"},  {31'h0, busy0},  32'h0);
    chk({tag, "_valid0"}, {31'h0, valid0}, 32'h0);
    chk({tag, "_res0"},   res0,  32'h0);
    chk({tag, "_ms1_0"},  ms1_0, 32'h0);
    chk({tag, "_ms2_0"},  ms2_0, 32'h0);
    chk({tag, "_busy1"},  {31'h0, busy1},  32'h0);
    chk({tag, "_valid1"}, {31'h0, valid1}, 32'h0);
    chk({tag, "_res1"},   res1,  32'h0);
    chk({tag, "_ms1_1"},  ms1_1, 32'h0);
    chk({tag, "_ms2_1"},  ms2_1, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] r0, r1, a, b;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full path with operand checks
    issue(32'h00010003, 32'h00020005, 1'b1, 1'b1);
    chk("t1_busy_c1", {31'h0, busy1}, 32'h1);
    chk("t1_ms1_issue1", ms1_1, 32'h00010003);
    chk("t1_ms2_issue1", ms2_1, 32'h00020005);
    @(negedge clk);
    chk("t1_busy_c2", {31'h0, busy1}, 32'h1);
    chk("t1_ms1_issue2", ms1_1, 32'h00000003);
    chk("t1_ms2_issue2", ms2_1, 32'h00000002);
    @(negedge clk);
    chk("t1_busy_c3", {31'h0, busy1}, 32'h1);
    chk("t1_ms1_finish", ms1_1, 32'h0);
    chk("t1_ms2_finish", ms2_1, 32'h0);

    // Early-out versus full path
    issue(32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_eo_ms1_issue2", ms1_1, 32'h0);
    chk("t2_eo_ms2_issue2", ms2_1, 32'h0);
    chk("t2_full_ms1_issue2", ms1_0, 32'h0000FFFF);
    @(negedge clk);
    chk("t2_eo_busy_c3", {31'h0, busy1}, 32'h0);
    chk("t2_full_busy_c3", {31'h0, busy0}, 32'h1);

    // Wrap-around
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);

    // Start held while busy, on each unit
    issue(32'h2, 32'h3, 1'b1, 1'b0);
    c = cyc - 1;
    hold_issue(32'h5, 32'h7, 1'b0, c + 4);
    issue(32'h2, 32'h3, 1'b0, 1'b1);
    c = cyc - 1;
    hold_issue(32'h5, 32'h7, 1'b1, c + 3);

    // Flush in ISSUE2
    wait_idle(1'b1, 1'b1);
    @(negedge clk);
    r0 = res0; r1 = res1;
    issue(32'h00010003, 32'h00020005, 1'b1, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_busy0_after_flush", {31'h0, busy0}, 32'h0);
    chk("t5_busy1_after_flush", {31'h0, busy1}, 32'h0);
    void'(q0.pop_back());
    void'(q1.pop_back());
    repeat (4) @(negedge clk);
    chk("t5_res0_kept", res0, r0);
    chk("t5_res1_kept", res1, r1);

    // Flush together with start in idle
    flush = 1'b1; start0 = 1'b1; start1 = 1'b1;
    src1 = 32'h9; src2 = 32'h9;
    @(negedge clk);
    flush = 1'b0; start0 = 1'b0; start1 = 1'b0;
    chk("t5_fs_busy0", {31'h0, busy0}, 32'h0);
    chk("t5_fs_busy1", {31'h0, busy1}, 32'h0);
    repeat (5) @(negedge clk);
    chk("t5_fs_res0_kept", res0, r0);
    chk("t5_fs_res1_kept", res1, r1);

    // Flush during the result_valid cycle does not retract it
    issue(32'h11111111, 32'h00050007, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t5_valid0_kept", {31'h0, valid0}, 32'h1);
    chk("t5_valid1_kept", {31'h0, valid1}, 32'h1);
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset in FINISH
    issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_zero_state("t6_async");
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(32'h0000FFFF, 32'hFFFF0001, 1'b1, 1'b1);

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[31:16] = 16'h0;
      if ($urandom_range(0, 5) == 0) a[15:0] = 16'hFFFF;
      issue(a, b, 1'b1, 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(q0.pop_back());
        void'(q1.pop_back());
      end
    end

    wait_idle(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
